// File: rtl/sm4_pkg.sv
// Shared SM4 key-schedule constants and helpers: FK words, CK generator,
// S-box, tau/L' transforms and the key-expansion state encoding.
package sm4_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EXPAND = 2'd1,
    ST_DONE   = 2'd2
  } sm4_state_e;

  localparam logic [127:0] FK_WORDS = 128'hA3B1BAC6_56AA3350_677D9197_B27022DC;

  // Byte x lives at bits [8*(255-x) +: 8], i.e. row 0 of the table is the top word.
  localparam logic [2047:0] SBOX_TBL = {
    128'hD690E9FECCE13DB716B614C228FB2C05, 128'h2B679A762ABE04C3AA44132649860699,
    128'h9C4250F491EF987A33540B43EDCFAC62, 128'hE4B31CA9C908E89580DF94FA758F3FA6,
    128'h4707A7FCF37317BA83593C19E6854FA8, 128'h686B81B27164DA8BF8EB0F4B70569D35,
    128'h1E240E5E6358D1A225227C3B01217887, 128'hD40046579FD327524C3602E7A0C4C89E,
    128'hEABF8AD240C738B5A3F7F2CEF96115A1, 128'hE0AE5DA49B341A55AD933230F58CB1E3,
    128'h1DF6E22E8266CA60C02923AB0D534E6F, 128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
    128'h8D1BAF92BBDDBC7F11D95C411F105AD8, 128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
    128'h8969974A0C96777E65B9F109C56EC684, 128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
  };

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[{~x, 3'b000} +: 8];
  endfunction

  function automatic logic [31:0] tau(input logic [31:0] a);
    return {sbox(a[31:24]), sbox(a[23:16]), sbox(a[15:8]), sbox(a[7:0])};
  endfunction

  function automatic logic [31:0] lp_key(input logic [31:0] b);
    return b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
  endfunction

  // CK[n] byte j (MSB first) = (4n+j)*7 mod 256; the 8-bit product wraps naturally.
  function automatic logic [31:0] ck(input logic [4:0] n);
    logic [31:0] res;
    res = '0;
    for (int j = 0; j < 4; j++) begin
      res[8*(3-j) +: 8] = 8'({1'b0, n, 2'(j)} * 8'd7);
    end
    return res;
  endfunction

endpackage

// File: rtl/sm4_keyexp_round.sv
// One combinational SM4 key-schedule round: rk[n] from the window K[n..n+3] and CK[n].
module sm4_keyexp_round
  import sm4_pkg::*;
(
  input  logic [31:0] k0_i,
  input  logic [31:0] k1_i,
  input  logic [31:0] k2_i,
  input  logic [31:0] k3_i,
  input  logic [31:0] ck_i,
  output logic [31:0] rk_o
);

  assign rk_o = k0_i ^ lp_key(tau(k1_i ^ k2_i ^ k3_i ^ ck_i));

endmodule

// File: rtl/sm4_keyexp_iter.sv
// Iterative SM4 key expansion: UNROLL chained rounds per cycle, one stored
// round-key array, encrypt/decrypt ordering applied at the output mux.
module sm4_keyexp_iter
  import sm4_pkg::*;
#(
  parameter int UNROLL = 1
) (
  input  logic          CLK_i,
  input  logic          RST_N_i,
  input  logic [127:0]  MK_i,
  input  logic          MK_VALID_i,
  input  logic          DEC_i,
  output logic          MK_READY_o,
  input  logic          ABORT_i,
  output logic [1023:0] RK_o,
  output logic          RK_VALID_o,
  input  logic [4:0]    RK_ADDR_i,
  output logic [31:0]   RK_RD_o,
  output logic [1:0]    dbg_state_o
);

  localparam int ITER  = 32 / UNROLL;
  localparam int CNT_W = (ITER > 1) ? $clog2(ITER) : 1;

  if (UNROLL != 1 && UNROLL != 2 && UNROLL != 4 && UNROLL != 8) begin : g_bad_unroll
    $error("sm4_keyexp_iter: UNROLL must be 1, 2, 4 or 8");
  end

  // Handshake: a key is taken on a rising edge where MK_VALID_i & MK_READY_o & ~ABORT_i;
  // MK_READY_o is low only while expanding. RK_VALID_o alone qualifies RK_o and RK_RD_o.
  sm4_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              dec_q, dec_d;
  logic [3:0][31:0]  win_q, win_d;   // win[0] is the oldest word K[n]
  logic [31:0][31:0] mem_q, mem_d;   // mem[i] holds rk[i] in generation order

  logic              mk_ready;
  logic              accept;
  logic              last_iter;
  logic [4:0]        base;
  logic [31:0]       rk_words [UNROLL];
  logic [3:0][31:0]  win_next;

  assign mk_ready  = (state_q != ST_EXPAND);
  assign accept    = MK_VALID_i & mk_ready & ~ABORT_i;
  assign last_iter = (cnt_q == CNT_W'(ITER - 1));
  assign base      = 5'(int'(cnt_q) * UNROLL);

  for (genvar i = 0; i < UNROLL; i++) begin : g_rnd
    logic [3:0][31:0] win_in;
    logic [3:0][31:0] win_out;
    logic [31:0]      rk_w;

    if (i == 0) begin : g_first
      assign win_in = win_q;
    end else begin : g_next
      assign win_in = g_rnd[i-1].win_out;
    end

    sm4_keyexp_round u_round (
      .k0_i (win_in[0]),
      .k1_i (win_in[1]),
      .k2_i (win_in[2]),
      .k3_i (win_in[3]),
      .ck_i (ck(base + 5'(i))),
      .rk_o (rk_w)
    );

    assign win_out     = {rk_w, win_in[3], win_in[2], win_in[1]};
    assign rk_words[i] = rk_w;
  end

  assign win_next = g_rnd[UNROLL-1].win_out;

  always_ff @(posedge CLK_i) begin
    if (!RST_N_i) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      dec_q   <= 1'b0;
      win_q   <= '0;
      mem_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      dec_q   <= dec_d;
      win_q   <= win_d;
      mem_q   <= mem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (ABORT_i) begin
      state_d = ST_IDLE;
    end else if (accept) begin
      state_d = ST_EXPAND;
    end else if (state_q == ST_EXPAND && last_iter) begin
      state_d = ST_DONE;
    end
  end

  always_comb begin
    cnt_d = cnt_q;
    dec_d = dec_q;
    win_d = win_q;
    mem_d = mem_q;
    if (ABORT_i) begin
      cnt_d = '0;
      win_d = '0;
      mem_d = '0;
    end else if (accept) begin
      cnt_d = '0;
      dec_d = DEC_i;
      for (int j = 0; j < 4; j++) begin
        win_d[j] = MK_i[32*(3-j) +: 32] ^ FK_WORDS[32*(3-j) +: 32];
      end
    end else if (state_q == ST_EXPAND) begin
      for (int i = 0; i < UNROLL; i++) begin
        mem_d[base + 5'(i)] = rk_words[i];
      end
      win_d = win_next;
      // Hold on the final pass so the counter never wraps.
      if (!last_iter) cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_comb begin
    MK_READY_o  = RST_N_i & mk_ready;
    RK_VALID_o  = RST_N_i & (state_q == ST_DONE);
    dbg_state_o = state_q;
    RK_o        = '0;
    RK_RD_o     = '0;
    if (RST_N_i) begin
      for (int s = 0; s < 32; s++) begin
        RK_o[32*(31-s) +: 32] = dec_q ? mem_q[31-s] : mem_q[s];
      end
      RK_RD_o = dec_q ? mem_q[~RK_ADDR_i] : mem_q[RK_ADDR_i];
    end
  end

endmodule

// File: tb/tb_sm4_keyexp_iter.sv
// Bench for sm4_keyexp_iter: four instances (UNROLL 1/2/4/8) driven in lockstep,
// checked against an array-based SM4 key-schedule model.
module tb_sm4_keyexp_iter;

  localparam int NU = 4;

  localparam logic [31:0] FK_T [4] = '{32'hA3B1BAC6, 32'h56AA3350, 32'h677D9197, 32'hB27022DC};
  localparam logic [2047:0] SB_FLAT = {
    128'hD690E9FECCE13DB716B614C228FB2C05, 128'h2B679A762ABE04C3AA44132649860699,
    128'h9C4250F491EF987A33540B43EDCFAC62, 128'hE4B31CA9C908E89580DF94FA758F3FA6,
    128'h4707A7FCF37317BA83593C19E6854FA8, 128'h686B81B27164DA8BF8EB0F4B70569D35,
    128'h1E240E5E6358D1A225227C3B01217887, 128'hD40046579FD327524C3602E7A0C4C89E,
    128'hEABF8AD240C738B5A3F7F2CEF96115A1, 128'hE0AE5DA49B341A55AD933230F58CB1E3,
    128'h1DF6E22E8266CA60C02923AB0D534E6F, 128'hD5DB3745DEFD8E2F03FF6A726D6C5B51,
    128'h8D1BAF92BBDDBC7F11D95C411F105AD8, 128'h0AC13188A5CD7BBD2D74D012B8E5B4B0,
    128'h8969974A0C96777E65B9F109C56EC684, 128'h18F07DEC3ADC4D2079EE5F3ED7CB3948
  };
  localparam logic [127:0] KAT_MK = 128'h0123456789ABCDEFFEDCBA9876543210;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst_n = 1'b0;
  logic [127:0] mk = '0;
  logic         mk_valid = 1'b0;
  logic         dec = 1'b0;
  logic         abort = 1'b0;
  logic [4:0]   rk_addr = '0;

  logic [1023:0] rk_w    [NU];
  logic          valid_w [NU];
  logic          ready_w [NU];
  logic [31:0]   rd_w    [NU];
  logic [1:0]    dbg_w   [NU];

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass = 0;

  logic [1023:0] exp_q [NU][$];
  int            acc_q [NU][$];

  // ---------------- reference model ----------------
  function automatic logic [7:0] sb(input logic [7:0] x);
    int idx;
    idx = 8 * (255 - int'(x));
    return SB_FLAT[idx +: 8];
  endfunction

  function automatic logic [31:0] ck_m(input int n);
    logic [31:0] r;
    for (int j = 0; j < 4; j++) r[8*(3-j) +: 8] = 8'(((4 * n + j) * 7) % 256);
    return r;
  endfunction

  function automatic logic [1023:0] model(input logic [127:0] key, input bit d);
    logic [31:0]   k [36];
    logic [31:0]   x, b;
    logic [1023:0] out;
    for (int j = 0; j < 4; j++) k[j] = key[127 - 32*j -: 32] ^ FK_T[j];
    for (int n = 0; n < 32; n++) begin
      x = k[n+1] ^ k[n+2] ^ k[n+3] ^ ck_m(n);
      b = {sb(x[31:24]), sb(x[23:16]), sb(x[15:8]), sb(x[7:0])};
      k[n+4] = k[n] ^ b ^ {b[18:0], b[31:19]} ^ {b[8:0], b[31:9]};
    end
    for (int s = 0; s < 32; s++) out[32*(31-s) +: 32] = d ? k[4 + 31 - s] : k[4 + s];
    return out;
  endfunction

  function automatic logic [31:0] slot(input logic [1023:0] v, input int s);
    return v[32*(31-s) +: 32];
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- check helpers ----------------
  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act === expv) n_pass++;
    else $display("FAIL %s got %h want %h", name, act, expv);
  endtask

  task automatic chk_rk(input string name, input logic [1023:0] act, input logic [1023:0] expv);
    int bad;
    n_checks++;
    if (act === expv) n_pass++;
    else begin
      bad = 0;
      for (int s = 31; s >= 0; s--) if (slot(act, s) !== slot(expv, s)) bad = s;
      $display("FAIL %s slot %0d got %h want %h", name, bad, slot(act, bad), slot(expv, bad));
    end
  endtask

  // ---------------- DUTs and monitors ----------------
  for (genvar g = 0; g < NU; g++) begin : g_dut
    sm4_keyexp_iter #(.UNROLL(1 << g)) u_dut (
      .CLK_i       (clk),
      .RST_N_i     (rst_n),
      .MK_i        (mk),
      .MK_VALID_i  (mk_valid),
      .DEC_i       (dec),
      .MK_READY_o  (ready_w[g]),
      .ABORT_i     (abort),
      .RK_o        (rk_w[g]),
      .RK_VALID_o  (valid_w[g]),
      .RK_ADDR_i   (rk_addr),
      .RK_RD_o     (rd_w[g]),
      .dbg_state_o (dbg_w[g])
    );

    logic prev_valid = 1'b0;

    always @(negedge clk) begin : mon
      logic [1023:0] e;
      int            a;
      if (rst_n) begin
        if (valid_w[g] && !prev_valid) begin
          if (exp_q[g].size() == 0) begin
            n_checks++;
            $display("FAIL spurious_valid_u%0d got 1 want 0", 1 << g);
          end else begin
            e = exp_q[g].pop_front();
            a = acc_q[g].pop_front();
            chk_rk($sformatf("rk_u%0d", 1 << g), rk_w[g], e);
            chk32($sformatf("latency_u%0d", 1 << g), 32'(cyc - a), 32'(32 >> g));
            chk32($sformatf("rd_u%0d", 1 << g), rd_w[g], slot(e, int'(rk_addr)));
          end
        end
        if (exp_q[g].size() != 0 && !valid_w[g])
          chk32($sformatf("ready_busy_u%0d", 1 << g), 32'(ready_w[g]), 32'd0);
      end
      prev_valid = valid_w[g];
    end
  end

  // ---------------- driver tasks ----------------
  task automatic push_exp(input logic [127:0] k, input bit d);
    logic [1023:0] m;
    m = model(k, d);
    for (int g = 0; g < NU; g++) begin
      exp_q[g].push_back(m);
      acc_q[g].push_back(cyc);
    end
  endtask

  task automatic clear_exp();
    for (int g = 0; g < NU; g++) begin
      exp_q[g].delete();
      acc_q[g].delete();
    end
  endtask

  task automatic issue(input logic [127:0] k, input bit d);
    @(negedge clk);
    mk = k; dec = d; mk_valid = 1'b1;
    rk_addr = 5'($urandom_range(0, 31));
    @(posedge clk); #1;
    push_exp(k, d);
    mk_valid = 1'b0;
    mk = rand128();
    dec = 1'($urandom_range(0, 1));
    @(negedge clk);
    for (int g = 0; g < NU; g++) begin
      chk32($sformatf("valid_drop_u%0d", 1 << g), 32'(valid_w[g]), 32'd0);
      chk32($sformatf("ready_expand_u%0d", 1 << g), 32'(ready_w[g]), 32'd0);
    end
  endtask

  task automatic wait_done();
    bit all;
    all = 1'b0;
    for (int t = 0; t < 100 && !all; t++) begin
      @(negedge clk);
      all = 1'b1;
      for (int g = 0; g < NU; g++) if (!valid_w[g]) all = 1'b0;
    end
    chk32("done_timeout", 32'(all), 32'd1);
  endtask

  task automatic check_idle_zero(input string tag, input bit want_ready);
    for (int g = 0; g < NU; g++) begin
      chk_rk($sformatf("%s_rk_u%0d", tag, 1 << g), rk_w[g], '0);
      chk32($sformatf("%s_rd_u%0d", tag, 1 << g), rd_w[g], 32'd0);
      chk32($sformatf("%s_valid_u%0d", tag, 1 << g), 32'(valid_w[g]), 32'd0);
      chk32($sformatf("%s_ready_u%0d", tag, 1 << g), 32'(ready_w[g]), 32'(want_ready));
    end
  endtask

  task automatic kat(input bit d);
    logic [31:0] first_w, last_w;
    first_w = d ? 32'h9124A012 : 32'hF12186F9;
    last_w  = d ? 32'hF12186F9 : 32'h9124A012;
    for (int g = 0; g < NU; g++) begin
      chk32($sformatf("kat_s0_u%0d", 1 << g), slot(rk_w[g], 0), first_w);
      chk32($sformatf("kat_s31_u%0d", 1 << g), slot(rk_w[g], 31), last_w);
      if (!d) chk32($sformatf("kat_s1_u%0d", 1 << g), slot(rk_w[g], 1), 32'h41662B61);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    logic [127:0] k;

    repeat (2) @(negedge clk);
    check_idle_zero("reset", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NU; g++) chk32($sformatf("ready_release_u%0d", 1 << g), 32'(ready_w[g]), 32'd1);

    issue(KAT_MK, 1'b0);
    wait_done();
    kat(1'b0);

    issue(KAT_MK, 1'b1);
    wait_done();
    kat(1'b1);
    rk_addr = 5'd31; #1;
    for (int g = 0; g < NU; g++) chk32($sformatf("kat_rd31_u%0d", 1 << g), rd_w[g], 32'hF12186F9);
    rk_addr = 5'd0; #1;
    for (int g = 0; g < NU; g++) chk32($sformatf("kat_rd0_u%0d", 1 << g), rd_w[g], 32'h9124A012);

    issue('0, 1'b0);
    wait_done();
    issue('0, 1'b1);
    wait_done();
    for (int i = 0; i < 6; i++) begin
      issue(rand128(), 1'($urandom_range(0, 1)));
      wait_done();
    end

    // Offers during EXPAND must be ignored.
    issue(rand128(), 1'($urandom_range(0, 1)));
    mk_valid = 1'b1; mk = rand128();
    @(negedge clk);
    mk = rand128(); dec = ~dec;
    @(negedge clk);
    mk_valid = 1'b0;
    wait_done();

    // Abort on EXPAND cycle 5 while a new key is offered.
    issue(rand128(), 1'($urandom_range(0, 1)));
    repeat (4) @(negedge clk);
    k = rand128();
    abort = 1'b1; mk_valid = 1'b1; mk = k; dec = 1'b1;
    @(posedge clk); #1;
    clear_exp();
    @(negedge clk);
    check_idle_zero("abort", 1'b1);
    abort = 1'b0;
    @(posedge clk); #1;
    push_exp(k, 1'b1);
    mk_valid = 1'b0;
    wait_done();

    // Reset on EXPAND cycle 10.
    issue(rand128(), 1'($urandom_range(0, 1)));
    repeat (9) @(negedge clk);
    rst_n = 1'b0;
    @(posedge clk); #1;
    clear_exp();
    @(negedge clk);
    check_idle_zero("midrst", 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    for (int g = 0; g < NU; g++) chk32($sformatf("ready_rerelease_u%0d", 1 << g), 32'(ready_w[g]), 32'd1);
    issue(rand128(), 1'($urandom_range(0, 1)));
    wait_done();

    repeat (2) @(negedge clk);
    for (int g = 0; g < NU; g++) chk32($sformatf("queue_empty_u%0d", 1 << g), 32'(exp_q[g].size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
